// File: rtl/mmu_walk_arbiter.sv
// mmu_walk_arbiter: shares the page-table walker between the ITLB and DTLB.
// One walk outstanding at a time; the owner's completion or fault is routed
// back to it, and the owner's abort is forwarded to the walker.
// Optional feature macro: MMU_ARB_ROUND_ROBIN_EN (alternate grants on ties);
// when undefined the DTLB wins ties.
// Walker result fields (superpage, upper physical address, perms) are wired
// from the walker to both TLBs outside this block.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no walk; arbitrate and latch the winner's request
// S_ISSUE  | pulse walk_request to the walker (unless the owner aborts)
// S_WAIT   | walk in flight; forward completion/fault or owner abort
// S_RELEASE| one idle cycle while the walker returns to its idle state

module mmu_walk_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_request,
  input  logic        d_request,
  input  logic [31:0] i_vaddr,
  input  logic [31:0] d_vaddr,
  input  logic        d_rnw,
  input  logic        i_abort,
  input  logic        d_abort,
  output logic        i_write_entry,
  output logic        i_is_fault,
  output logic        d_write_entry,
  output logic        d_is_fault,
  output logic        walk_request,
  output logic [31:0] walk_vaddr,
  output logic        walk_rnw,
  output logic        walk_execute,
  output logic        walk_abort,
  input  logic        walk_write_entry,
  input  logic        walk_is_fault
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_ISSUE   = 4'b0010,
    S_WAIT    = 4'b0100,
    S_RELEASE = 4'b1000
  } state_t;

  // Owner encoding: 1 = ITLB, 0 = DTLB.
  localparam logic OWN_I = 1'b1;
  localparam logic OWN_D = 1'b0;

  state_t      r_state;
  logic        r_owner;
  logic        r_last_owner;
  logic [31:0] r_vaddr;
  logic        r_rnw;
  logic        r_execute;

  logic w_i_req;
  logic w_d_req;
  logic w_any_req;
  logic w_grant_i;
  logic w_owner_abort;
  logic w_busy;
  logic w_done;

  // A request whose own abort arrives in the same cycle does not compete.
  assign w_i_req   = i_request & ~i_abort;
  assign w_d_req   = d_request & ~d_abort;
  assign w_any_req = w_i_req | w_d_req;

  // Winner selection among the masked requests.
  always_comb begin
    w_grant_i = 1'b0;
`ifdef MMU_ARB_ROUND_ROBIN_EN
    if (w_i_req && w_d_req) w_grant_i = (r_last_owner == OWN_D);
    else                    w_grant_i = w_i_req;
`else
    w_grant_i = w_i_req & ~w_d_req;
`endif
  end

  assign w_owner_abort = (r_owner == OWN_I) ? i_abort : d_abort;
  assign w_busy        = (r_state == S_ISSUE) || (r_state == S_WAIT);
  // Abort beats a completion landing in the same cycle.
  assign w_done        = (r_state == S_WAIT) & ~w_owner_abort
                         & (walk_write_entry | walk_is_fault);

  assign walk_request  = (r_state == S_ISSUE) & ~w_owner_abort;
  assign walk_abort    = w_busy & w_owner_abort;
  assign walk_vaddr    = r_vaddr;
  assign walk_rnw      = r_rnw;
  assign walk_execute  = r_execute;

  assign i_write_entry = w_done & (r_owner == OWN_I) & walk_write_entry;
  assign i_is_fault    = w_done & (r_owner == OWN_I) & walk_is_fault;
  assign d_write_entry = w_done & (r_owner == OWN_D) & walk_write_entry;
  assign d_is_fault    = w_done & (r_owner == OWN_D) & walk_is_fault;

  // Arbitration FSM with registered owner and walker request fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_D;
      r_last_owner <= OWN_D;
      r_vaddr      <= 32'h0;
      r_rnw        <= 1'b0;
      r_execute    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_ISSUE;
            if (w_grant_i) begin
              r_owner   <= OWN_I;
              r_vaddr   <= i_vaddr;
              r_rnw     <= 1'b1;
              r_execute <= 1'b1;
            end else begin
              r_owner   <= OWN_D;
              r_vaddr   <= d_vaddr;
              r_rnw     <= d_rnw;
              r_execute <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          r_state <= w_owner_abort ? S_RELEASE : S_WAIT;
        end
        S_WAIT: begin
          if (w_owner_abort) begin
            r_state <= S_RELEASE;
          end else if (walk_write_entry || walk_is_fault) begin
            r_last_owner <= r_owner;
            r_state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The walker should only complete while a walk is in flight.
  a_unexpected_completion: assert property (@(posedge clk) disable iff (!rst)
    (walk_write_entry || walk_is_fault) |-> (r_state == S_WAIT));

  // A forwarded completion always records its owner as the last owner.
  a_last_owner_tracks: assert property (@(posedge clk) disable iff (!rst)
    ((r_state == S_RELEASE) && $past(w_done)) |-> (r_last_owner == r_owner));

endmodule

// File: tb/tb_mmu_walk_arbiter.sv
// Bench for mmu_walk_arbiter: transaction-timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mmu_walk_arbiter;

  logic        clk;
  logic        rst;
  logic        i_request, d_request;
  logic [31:0] i_vaddr, d_vaddr;
  logic        d_rnw, i_abort, d_abort;
  logic        i_write_entry, i_is_fault, d_write_entry, d_is_fault;
  logic        walk_request;
  logic [31:0] walk_vaddr;
  logic        walk_rnw, walk_execute, walk_abort;
  logic        walk_write_entry, walk_is_fault;

  int n_cmp = 0;
  int n_bad = 0;
  int tb_cyc = 0;

  mmu_walk_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .i_request        (i_request),
    .d_request        (d_request),
    .i_vaddr          (i_vaddr),
    .d_vaddr          (d_vaddr),
    .d_rnw            (d_rnw),
    .i_abort          (i_abort),
    .d_abort          (d_abort),
    .i_write_entry    (i_write_entry),
    .i_is_fault       (i_is_fault),
    .d_write_entry    (d_write_entry),
    .d_is_fault       (d_is_fault),
    .walk_request     (walk_request),
    .walk_vaddr       (walk_vaddr),
    .walk_rnw         (walk_rnw),
    .walk_execute     (walk_execute),
    .walk_abort       (walk_abort),
    .walk_write_entry (walk_write_entry),
    .walk_is_fault    (walk_is_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, tb_cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A walk is a record: owner, cycle its request pulse is due, and the cycle
  // from which the arbiter may accept a new request.
  bit          m_init = 0;
  int          m_cyc = 0;
  bit          m_active = 0;
  int          m_issue_at = 0;
  int          m_free_at = 0;
  bit          m_owner_i = 0;
  bit          m_last_i = 0;
  logic [31:0] m_vaddr = 0;
  bit          m_rnw = 0;
  bit          m_exec = 0;

  always @(negedge clk) begin
    bit oab, e_req, e_ab, e_iwe, e_ifl, e_dwe, e_dfl, ir, dr, win_i, fin;
    oab = m_owner_i ? i_abort : d_abort;
    e_req = 0; e_ab = 0; e_iwe = 0; e_ifl = 0; e_dwe = 0; e_dfl = 0; fin = 0;
    if (m_active && m_cyc >= m_issue_at) begin
      if (oab) begin
        e_ab = 1; fin = 1;
      end else if (m_cyc == m_issue_at) begin
        e_req = 1;
      end else if (walk_write_entry || walk_is_fault) begin
        fin = 1;
        e_iwe = m_owner_i & walk_write_entry;
        e_ifl = m_owner_i & walk_is_fault;
        e_dwe = !m_owner_i & walk_write_entry;
        e_dfl = !m_owner_i & walk_is_fault;
      end
    end
    if (m_init) begin
      chk("m_walk_request", walk_request, e_req);
      chk("m_walk_abort", walk_abort, e_ab);
      chk("m_i_write_entry", i_write_entry, e_iwe);
      chk("m_i_is_fault", i_is_fault, e_ifl);
      chk("m_d_write_entry", d_write_entry, e_dwe);
      chk("m_d_is_fault", d_is_fault, e_dfl);
      chk("m_walk_vaddr", walk_vaddr, m_vaddr);
      chk("m_walk_rnw", walk_rnw, m_rnw);
      chk("m_walk_execute", walk_execute, m_exec);
    end
    if (rst !== 1'b1) begin
      m_init = 1; m_active = 0; m_owner_i = 0; m_last_i = 0;
      m_vaddr = 0; m_rnw = 0; m_exec = 0; m_free_at = m_cyc + 1;
    end else if (fin) begin
      if (!oab) m_last_i = m_owner_i;
      m_active = 0;
      m_free_at = m_cyc + 2;
    end else if (!m_active && m_cyc >= m_free_at) begin
      ir = i_request & ~i_abort;
      dr = d_request & ~d_abort;
      if (ir || dr) begin
`ifdef MMU_ARB_ROUND_ROBIN_EN
        win_i = (ir && dr) ? !m_last_i : ir;
`else
        win_i = ir && !dr;
`endif
        m_active = 1; m_issue_at = m_cyc + 1; m_owner_i = win_i;
        m_vaddr = win_i ? i_vaddr : d_vaddr;
        m_rnw = win_i ? 1'b1 : d_rnw;
        m_exec = win_i;
      end
    end
    m_cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int t, output bit own_i);
    bit found;
    found = 0; t = 0; own_i = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (walk_request === 1'b1) begin
        found = 1; t = tb_cyc; own_i = walk_execute;
      end
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_req actual=timeout required=walk_request pulse");
    end
  endtask

  task automatic complete(input int lat, input bit fault, input bit own_i, output int tc);
    logic ip, dp;
    repeat (lat) tick();
    if (fault) walk_is_fault = 1; else walk_write_entry = 1;
    @(negedge clk);
    tc = tb_cyc;
    ip = fault ? i_is_fault : i_write_entry;
    dp = fault ? d_is_fault : d_write_entry;
    chk("pulse_owner", own_i ? ip : dp, 1);
    chk("pulse_other", own_i ? dp : ip, 0);
    tick();
    walk_is_fault = 0; walk_write_entry = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_order;
  int t, t0, tc, ta, prev;
  bit own;

  initial begin
    rst = 0; i_request = 1; d_request = 1;
    i_vaddr = 32'h0040_2000; d_vaddr = 32'h8000_1000; d_rnw = 1;
    i_abort = 0; d_abort = 0; walk_write_entry = 0; walk_is_fault = 0;

    // Reset held 3 cycles with both requests high.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulses", {walk_request, walk_abort, i_write_entry, i_is_fault,
                       d_write_entry, d_is_fault}, 0);
    chk("rst_vaddr", walk_vaddr, 0);
    chk("rst_rnw_exec", {walk_rnw, walk_execute}, 0);
    rst = 1;
    @(negedge clk);
    t0 = tb_cyc;
    chk("rst_no_req_yet", walk_request, 0);
    wait_req(t, own);
    chk("rst_latency", t - t0, 1);
`ifdef MMU_ARB_ROUND_ROBIN_EN
    chk("rst_vaddr_grant", walk_vaddr, 32'h0040_2000);
    chk("rst_exec_grant", walk_execute, 1);
`else
    chk("rst_vaddr_grant", walk_vaddr, 32'h8000_1000);
    chk("rst_exec_grant", walk_execute, 0);
`endif
    complete(3, 0, own, tc);
    i_request = 0; d_request = 0;
    tick();

    // Single ITLB walk, walker completes 6 cycles after the request pulse.
    i_request = 1;
    wait_req(t, own);
    chk("itlb_owner", own, 1);
    chk("itlb_vaddr", walk_vaddr, 32'h0040_2000);
    chk("itlb_rnw", walk_rnw, 1);
    chk("itlb_exec", walk_execute, 1);
    complete(6, 0, own, tc);
    i_request = 0;
    tick();

    // Contention: both held for 4 walks.
`ifdef MMU_ARB_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    d_rnw = 0; i_request = 1; d_request = 1; prev = 0;
    for (int w = 0; w < 4; w++) begin
      wait_req(t, own);
      chk($sformatf("grant_order_%0d", w), own, exp_order[w]);
      if (w > 0) chk($sformatf("grant_gap_%0d", w), t - prev, 3);
      complete(2, 0, own, prev);
    end
    i_request = 0; d_request = 0;
    tick(); tick();

    // Owner abort in WAIT.
    d_rnw = 1; d_request = 1;
    wait_req(t, own);
    chk("dabort_owner", own, 0);
    tick(); tick();
    d_abort = 1; d_request = 0;
    @(negedge clk);
    ta = tb_cyc;
    chk("dabort_walk_abort", walk_abort, 1);
    chk("dabort_no_entry", d_write_entry, 0);
    tick();
    d_abort = 0; d_request = 1;
    wait_req(t, own);
    chk("dabort_regrant_gap", t - ta, 3);
    complete(2, 0, own, tc);
    d_request = 0;
    tick();

    // Abort colliding with a fault: abort wins.
    i_request = 1;
    wait_req(t, own);
    repeat (3) tick();
    i_abort = 1; walk_is_fault = 1; i_request = 0;
    @(negedge clk);
    chk("collide_no_fault", i_is_fault, 0);
    chk("collide_walk_abort", walk_abort, 1);
    tick();
    i_abort = 0; walk_is_fault = 0;
    tick(); tick();

    // Request masked by its own abort in IDLE.
    i_request = 1; i_abort = 1;
    tick();
    i_request = 0; i_abort = 0;
    @(negedge clk);
    chk("mask_no_req", walk_request, 0);
    tick();

    // Non-owner abort during WAIT is ignored.
    d_request = 1;
    wait_req(t, own);
    tick();
    i_abort = 1;
    @(negedge clk);
    chk("nonowner_abort", walk_abort, 0);
    tick();
    i_abort = 0;
    complete(1, 1, own, tc);
    d_request = 0;
    tick();

    // Reset mid-walk.
    i_request = 1;
    wait_req(t, own);
    tick(); tick();
    rst = 0; i_request = 0;
    tick();
    rst = 1;
    @(negedge clk);
    chk("midrst_outputs", {walk_request, walk_abort, walk_rnw, walk_execute}, 0);
    chk("midrst_vaddr", walk_vaddr, 0);
    repeat (3) tick();
    d_request = 1;
    wait_req(t, own);
    chk("midrst_regrant_owner", own, 0);
    complete(2, 0, own, tc);
    d_request = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
